// File: rtl/jtgng_inputs_if.sv
// Player-input bus between hps_io/keyboard sources and the game core.
// The master side drives raw inputs; the slave (jtgng_inputs) returns active-low buttons.
interface jtgng_inputs_if #(
    parameter int PLAYERS = 2,
    parameter int BUTTONS = 2
);
    logic [10:0]            ps2_key;
    logic [16*PLAYERS-1:0]  joy;
    logic                   vs;
    logic                   autofire_en;
    logic [BUTTONS+3:0]     joystick1;
    logic [BUTTONS+3:0]     joystick2;
    logic [1:0]             start_button;
    logic [1:0]             coin_input;
    logic                   service;
    logic                   dip_pause;

    modport master (
        output ps2_key, joy, vs, autofire_en,
        input  joystick1, joystick2, start_button, coin_input, service, dip_pause
    );

    modport slave (
        input  ps2_key, joy, vs, autofire_en,
        output joystick1, joystick2, start_button, coin_input, service, dip_pause
    );
endinterface

// File: rtl/jtgng_inputs.sv
// Merges PS/2 keys and HPS joysticks into active-low game buttons, with
// fixed-width coin pulses, a pause toggle and frame-locked autofire.
module jtgng_inputs #(
    parameter int PLAYERS     = 2,
    parameter int BUTTONS     = 2,
    parameter int COIN_CYCLES = 2400,
    parameter int AF_FRAMES   = 2
)(
    input  logic          clk,
    input  logic          rst,
    jtgng_inputs_if.slave bus
);
    localparam int CW = $clog2(COIN_CYCLES + 1);
    localparam int FW = (AF_FRAMES > 1) ? $clog2(AF_FRAMES) : 1;
    localparam int JW = BUTTONS + 4;
    localparam int KB = (BUTTONS < 3) ? BUTTONS : 3;

    typedef struct packed {
        logic [3:0] dir;   // up, down, left, right
        logic [2:0] btn;
    } player_keys_t;

    typedef struct packed {
        player_keys_t p1;
        player_keys_t p2;
        logic start1, start2, coin1, coin2, pause, test;
    } key_state_t;

    logic              tog;
    key_state_t        keys;
    logic              pressed;

    logic [31:0]       joy_w;
    logic [JW-1:0]     m1, m2;
    logic              m_start1, m_start2, m_pause;
    logic [1:0]        m_coin;
    logic              unused_bits;

    logic [1:0]        coin_last;
    logic [1:0][CW-1:0] coin_cnt;
    logic              pause_last, paused;
    logic              vs_last, af_phase;
    logic [FW-1:0]     frame_cnt;

    assign pressed = bus.ps2_key[9];

    // tog is loaded from the live toggle bit in reset so release never looks like an event
    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            tog  <= bus.ps2_key[10];
            keys <= '0;
        end else begin
            tog <= bus.ps2_key[10];
            if (bus.ps2_key[10] != tog) begin
                case (bus.ps2_key[7:0])
                    8'h75: keys.p1.dir[3] <= pressed;
                    8'h72: keys.p1.dir[2] <= pressed;
                    8'h6B: keys.p1.dir[1] <= pressed;
                    8'h74: keys.p1.dir[0] <= pressed;
                    8'h14: keys.p1.btn[0] <= pressed;
                    8'h11: keys.p1.btn[1] <= pressed;
                    8'h29: keys.p1.btn[2] <= pressed;
                    8'h2D: keys.p2.dir[3] <= pressed;
                    8'h2B: keys.p2.dir[2] <= pressed;
                    8'h23: keys.p2.dir[1] <= pressed;
                    8'h34: keys.p2.dir[0] <= pressed;
                    8'h1C: keys.p2.btn[0] <= pressed;
                    8'h1B: keys.p2.btn[1] <= pressed;
                    8'h15: keys.p2.btn[2] <= pressed;
                    8'h05: keys.start1    <= pressed;
                    8'h06: keys.start2    <= pressed;
                    8'h04: keys.coin1     <= pressed;
                    8'h0B: keys.coin2     <= pressed;
                    8'h0C: keys.pause     <= pressed;
                    8'h03: keys.test      <= pressed;
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [JW-1:0] merge(input logic [15:0] j, input player_keys_t k);
        logic [JW-1:0] r;
        r      = j[JW-1:0];
        r[3:0] = r[3:0] | k.dir;
        for (int i = 0; i < KB; i++) r[4+i] = r[4+i] | k.btn[i];
        return r;
    endfunction

    always_comb begin
        // NOTE: every signal gets a value on every path here, so no latches are inferred.
        joy_w    = 32'(bus.joy);
        m1       = merge(joy_w[15:0], keys.p1);
        m2       = (PLAYERS > 1) ? merge(joy_w[31:16], keys.p2) : '0;
        m_start1 = keys.start1 | joy_w[BUTTONS+4] | joy_w[16+BUTTONS+4];
        m_start2 = keys.start2 | joy_w[BUTTONS+5] | joy_w[16+BUTTONS+5];
        m_coin   = {keys.coin2 | joy_w[16+BUTTONS+6], keys.coin1 | joy_w[BUTTONS+6]};
        m_pause  = keys.pause | joy_w[BUTTONS+7] | joy_w[16+BUTTONS+7];
        if (bus.autofire_en && !af_phase) begin
            m1[4] = 1'b0;
            m2[4] = 1'b0;
        end
    end

    assign unused_bits = ^{bus.ps2_key[8], joy_w};

    always_ff @(posedge clk) begin
        if (rst) begin
            coin_last        <= '0;
            coin_cnt         <= '0;
            pause_last       <= 1'b0;
            paused           <= 1'b0;
            vs_last          <= 1'b0;
            frame_cnt        <= '0;
            af_phase         <= 1'b1;
            bus.joystick1    <= '1;
            bus.joystick2    <= '1;
            bus.start_button <= '1;
            bus.coin_input   <= '1;
            bus.service      <= 1'b1;
            bus.dip_pause    <= 1'b1;
        end else begin
            coin_last  <= m_coin;
            pause_last <= m_pause;
            vs_last    <= bus.vs;

            if (m_pause && !pause_last) paused <= !paused;

            if (bus.vs && !vs_last) begin
                if (frame_cnt == FW'(AF_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    af_phase  <= !af_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            // A new pulse is only armed once the previous one is visibly over
            for (int p = 0; p < 2; p++) begin
                if (m_coin[p] && !coin_last[p] && coin_cnt[p] == '0 && bus.coin_input[p])
                    coin_cnt[p] <= CW'(COIN_CYCLES);
                else if (coin_cnt[p] != '0)
                    coin_cnt[p] <= coin_cnt[p] - 1'b1;
                bus.coin_input[p] <= (coin_cnt[p] == '0);
            end

            bus.joystick1    <= ~m1;
            bus.joystick2    <= ~m2;
            bus.start_button <= ~{m_start2, m_start1};
            bus.service      <= ~keys.test;
            bus.dip_pause    <= ~paused;
        end
    end
endmodule

// File: tb/tb_jtgng_inputs.sv
// Self-checking bench for jtgng_inputs: vector table, directed corner sequences,
// then random stimulus against an event/count-based reference model.
module tb_jtgng_inputs;
    localparam int PLAYERS     = 2;
    localparam int BUTTONS     = 2;
    localparam int COIN_CYCLES = 10;
    localparam int AF_FRAMES   = 2;

    logic clk;
    logic rst;

    jtgng_inputs_if #(.PLAYERS(PLAYERS), .BUTTONS(BUTTONS)) bus ();

    jtgng_inputs #(
        .PLAYERS(PLAYERS), .BUTTONS(BUTTONS),
        .COIN_CYCLES(COIN_CYCLES), .AF_FRAMES(AF_FRAMES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [10:0] ps2;
        logic [31:0] joy;
        logic        vs;
        logic        af;
    } stim_t;

    typedef struct packed {
        logic [5:0] j1;
        logic [5:0] j2;
        logic [1:0] start;
        logic [1:0] coin;
        logic       service;
        logic       dip;
    } outs_t;

    typedef struct {
        logic [31:0] joy;
        logic [5:0]  j1;
        logic [5:0]  j2;
        logic [1:0]  start;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic outs_t get_outs();
        return {bus.joystick1, bus.joystick2, bus.start_button, bus.coin_input,
                bus.service, bus.dip_pause};
    endfunction

    task automatic key_event(input logic [7:0] code, input logic press);
        bus.ps2_key = {~bus.ps2_key[10], press, 1'b0, code};
    endtask

    // ---------------- reference model ----------------
    logic [7:0] dir_code [2][4] = '{'{8'h74, 8'h6B, 8'h72, 8'h75}, '{8'h34, 8'h23, 8'h2B, 8'h2D}};
    logic [7:0] btn_code [2][3] = '{'{8'h14, 8'h11, 8'h29}, '{8'h1C, 8'h1B, 8'h15}};
    logic [7:0] codes [20] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h2D, 8'h2B, 8'h23,
                               8'h34, 8'h1C, 8'h1B, 8'h15, 8'h05, 8'h06, 8'h04, 8'h0B, 8'h0C, 8'h03};

    bit pressed [256];
    bit prev_tog, prev_pause, prev_vs;
    bit prev_coin [2];
    int last_coin [2];
    int pause_edges, vs_edges, cyc;

    // Expected outputs after the next clock edge given the inputs held across it
    task automatic model_edge(input stim_t s, output outs_t e);
        logic [11:0] v [2];
        logic        phase, mst1, mst2, mp;
        logic [1:0]  mc;
        if (s.rst) begin
            e = '1;
            foreach (pressed[i]) pressed[i] = 1'b0;
            prev_tog = s.ps2[10];
            prev_pause = 1'b0; prev_vs = 1'b0;
            prev_coin[0] = 1'b0; prev_coin[1] = 1'b0;
            last_coin[0] = -100; last_coin[1] = -100;
            pause_edges = 0; vs_edges = 0;
            cyc++;
            return;
        end
        phase = ((vs_edges / AF_FRAMES) % 2) == 0;
        for (int p = 0; p < 2; p++) begin
            v[p] = {6'b0, s.joy[16*p +: 6]};
            for (int d = 0; d < 4; d++) if (pressed[dir_code[p][d]]) v[p][d] = 1'b1;
            for (int b = 0; b < 3; b++) if (b < BUTTONS && pressed[btn_code[p][b]]) v[p][4+b] = 1'b1;
            if (s.af && !phase) v[p][4] = 1'b0;
        end
        mst1  = pressed[8'h05] | s.joy[6] | s.joy[22];
        mst2  = pressed[8'h06] | s.joy[7] | s.joy[23];
        mc[0] = pressed[8'h04] | s.joy[8];
        mc[1] = pressed[8'h0B] | s.joy[24];
        mp    = pressed[8'h0C] | s.joy[9] | s.joy[25];

        e.j1      = ~v[0][5:0];
        e.j2      = ~v[1][5:0];
        e.start   = ~{mst2, mst1};
        for (int c = 0; c < 2; c++)
            e.coin[c] = !(cyc >= last_coin[c] + 1 && cyc <= last_coin[c] + COIN_CYCLES);
        e.service = ~pressed[8'h03];
        e.dip     = (pause_edges % 2) == 0;

        if (mp && !prev_pause) pause_edges++;
        for (int c = 0; c < 2; c++) begin
            if (mc[c] && !prev_coin[c] && cyc >= last_coin[c] + COIN_CYCLES + 2) last_coin[c] = cyc;
            prev_coin[c] = mc[c];
        end
        if (s.vs && !prev_vs) vs_edges++;
        if (s.ps2[10] != prev_tog) pressed[s.ps2[7:0]] = s.ps2[9];
        prev_tog   = s.ps2[10];
        prev_pause = mp;
        prev_vs    = s.vs;
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        vec_t  vecs [10];
        stim_t s;
        outs_t e, a;
        int    lows, falls, both;
        logic  last_c;

        vecs[0] = '{32'h0000_0000, 6'h3F, 6'h3F, 2'b11};
        vecs[1] = '{32'h0000_0001, 6'h3E, 6'h3F, 2'b11};
        vecs[2] = '{32'h0000_0008, 6'h37, 6'h3F, 2'b11};
        vecs[3] = '{32'h0010_0000, 6'h3F, 6'h2F, 2'b11};
        vecs[4] = '{32'h0000_0030, 6'h0F, 6'h3F, 2'b11};
        vecs[5] = '{32'h0040_0000, 6'h3F, 6'h3F, 2'b10};
        vecs[6] = '{32'h0000_0080, 6'h3F, 6'h3F, 2'b01};
        vecs[7] = '{32'h0080_0040, 6'h3F, 6'h3F, 2'b00};
        vecs[8] = '{32'h000F_000F, 6'h30, 6'h30, 2'b11};
        vecs[9] = '{32'hFC00_FC00, 6'h3F, 6'h3F, 2'b11};

        rst = 1'b1;
        bus.ps2_key = '0; bus.joy = '0; bus.vs = 1'b0; bus.autofire_en = 1'b0;
        @(negedge clk);

        // Reset with random inputs and key toggles
        for (int i = 0; i < 3; i++) begin
            bus.joy = $urandom;
            bus.vs  = 1'($urandom_range(0, 1));
            bus.ps2_key = {~bus.ps2_key[10], 1'b1, 1'b0, 8'h74};
            tick();
            check("reset_outs", 32'(get_outs()), 32'(18'h3FFFF));
        end
        bus.joy = '0; bus.vs = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_key_after_reset", 32'(get_outs()), 32'(18'h3FFFF));
        end

        // Joystick routing table
        foreach (vecs[i]) begin
            bus.joy = vecs[i].joy;
            tick();
            check($sformatf("vec%0d_j1", i), 32'(bus.joystick1), 32'(vecs[i].j1));
            check($sformatf("vec%0d_j2", i), 32'(bus.joystick2), 32'(vecs[i].j2));
            check($sformatf("vec%0d_start", i), 32'(bus.start_button), 32'(vecs[i].start));
        end
        bus.joy = '0;
        tick();

        // Keyboard latency: press then release P1 right
        key_event(8'h74, 1'b1);
        tick(); check("kbd_lat", 32'(bus.joystick1), 32'h3F);
        tick(); check("kbd_press", 32'(bus.joystick1), 32'h3E);
        check("kbd_p2_idle", 32'(bus.joystick2), 32'h3F);
        key_event(8'h74, 1'b0);
        tick(); check("kbd_rel_lat", 32'(bus.joystick1), 32'h3E);
        tick(); check("kbd_release", 32'(bus.joystick1), 32'h3F);
        check("kbd_p2_idle2", 32'(bus.joystick2), 32'h3F);

        // Button 2 key does nothing with two buttons
        key_event(8'h29, 1'b1);
        tick(); tick(); check("b2_ignored", 32'(get_outs()), 32'(18'h3FFFF));
        key_event(8'h29, 1'b0);
        tick();

        // P2 button 0 key only reaches player 2
        key_event(8'h1C, 1'b1);
        tick(); tick();
        check("p2_key_j2", 32'(bus.joystick2), 32'h2F);
        check("p2_key_j1", 32'(bus.joystick1), 32'h3F);
        key_event(8'h1C, 1'b0);
        tick(); tick();

        // Test key drives service
        key_event(8'h03, 1'b1);
        tick(); tick(); check("service_on", 32'(bus.service), 32'h0);
        key_event(8'h03, 1'b0);
        tick(); tick(); check("service_off", 32'(bus.service), 32'h1);

        // Press and release in consecutive cycles
        key_event(8'h6B, 1'b1);
        tick();
        key_event(8'h6B, 1'b0);
        tick(); check("pr_press", 32'(bus.joystick1), 32'h3D);
        tick(); check("pr_release", 32'(bus.joystick1), 32'h3F);

        // Key event and joystick change in the same cycle
        key_event(8'h75, 1'b1);
        bus.joy = 32'h1;
        tick(); check("simul_joy", 32'(bus.joystick1), 32'h3E);
        tick(); check("simul_both", 32'(bus.joystick1), 32'h36);
        key_event(8'h75, 1'b0);
        bus.joy = '0;
        tick(); tick();

        // Joystick 2 coin bit pulses slot 2
        bus.joy = 32'h0100_0000;
        tick(); check("coin2_lat", 32'(bus.coin_input), 32'h3);
        tick(); check("coin2_low", 32'(bus.coin_input), 32'h1);
        lows = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus.coin_input[1]) lows++;
        end
        check("coin2_width", 32'(lows), 32'(COIN_CYCLES));
        bus.joy = '0;
        tick();

        // Coin key held 50 cycles with a re-press mid-pulse
        key_event(8'h04, 1'b1);
        lows = 0; falls = 0; last_c = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i == 5) key_event(8'h04, 1'b0);
            if (i == 6) key_event(8'h04, 1'b1);
            if (i == 50) key_event(8'h04, 1'b0);
            tick();
            if (!bus.coin_input[0]) lows++;
            if (last_c && !bus.coin_input[0]) falls++;
            last_c = bus.coin_input[0];
        end
        check("coin1_width", 32'(lows), 32'(COIN_CYCLES));
        check("coin1_once", 32'(falls), 32'h1);

        // Both slots in the same cycle
        bus.joy = 32'h0100_0100;
        tick(); tick();
        check("coin_both", 32'(bus.coin_input), 32'h0);
        both = 1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus.coin_input == 2'b00) both++;
        end
        check("coin_both_width", 32'(both), 32'(COIN_CYCLES));
        bus.joy = '0;
        tick();

        // Pause toggling and reset while paused
        for (int n = 0; n < 3; n++) begin
            key_event(8'h0C, 1'b1);
            tick();
            key_event(8'h0C, 1'b0);
            tick();
            if (n < 2) begin
                check($sformatf("pause%0d_lat", n), 32'(bus.dip_pause), 32'(n % 2 == 0));
                tick();
                check($sformatf("pause%0d", n), 32'(bus.dip_pause), 32'(n % 2 == 1));
            end else begin
                tick();
                check("pause_before_rst", 32'(bus.dip_pause), 32'h0);
            end
        end
        rst = 1'b1;
        tick(); check("rst_while_paused", 32'(get_outs()), 32'(18'h3FFFF));
        rst = 1'b0;
        tick(); check("unpaused_after_rst", 32'(bus.dip_pause), 32'h1);

        // Autofire over 8 frames, counted from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.joy = 32'h30;
        bus.autofire_en = 1'b1;
        for (int f = 0; f < 8; f++) begin
            tick(); tick(); tick();
            check($sformatf("af_frame%0d_b0", f), 32'(bus.joystick1[4]), 32'(((f / AF_FRAMES) % 2) != 0));
            check($sformatf("af_frame%0d_b1", f), 32'(bus.joystick1[5]), 32'h0);
            bus.vs = 1'b1;
            tick();
            bus.vs = 1'b0;
        end
        bus.autofire_en = 1'b0;
        tick(); check("af_off", 32'(bus.joystick1[4]), 32'h0);
        bus.joy = '0;

        // Random stimulus against the reference model
        s = '0;
        s.rst = 1'b1;
        s.ps2[10] = bus.ps2_key[10];
        for (int i = 0; i < 3000; i++) begin
            if (i > 0) begin
                int idx;
                s.rst = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 5) == 0) begin
                    s.ps2[10] = ~s.ps2[10];
                    s.ps2[9]  = 1'($urandom_range(0, 1));
                    s.ps2[7:0] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : codes[$urandom_range(0, 19)];
                end else if ($urandom_range(0, 3) == 0) begin
                    s.ps2[9]   = 1'($urandom_range(0, 1));
                    s.ps2[7:0] = codes[$urandom_range(0, 19)];
                end
                s.ps2[8] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 2) == 0) begin
                    idx = $urandom_range(0, 31);
                    s.joy[idx] = ~s.joy[idx];
                end
                if ($urandom_range(0, 4) == 0) s.vs = ~s.vs;
                if ($urandom_range(0, 49) == 0) s.af = ~s.af;
            end
            rst = s.rst;
            bus.ps2_key = s.ps2;
            bus.joy = s.joy;
            bus.vs = s.vs;
            bus.autofire_en = s.af;
            model_edge(s, e);
            tick();
            a = get_outs();
            if (a !== e) $display("FAIL random cycle %0d: got %h, expected %h", i, a, e);
            check("random", 32'(a), 32'(e));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
